// File: rtl/taxi_qsfp_mgmt_seq.sv
// taxi_qsfp_mgmt_seq: per-port QSFP sideband sequencer (presence debounce, reset/t_init, IntL latch, ModSelL).
// Optional status LEDs are enabled by defining TAXI_QSFP_MGMT_LED_EN.  Rev 1.0
`default_nettype none

module taxi_qsfp_mgmt_seq #(
    parameter int PORT_CNT     = 2,
    parameter int DEBOUNCE_CYC = 125000,
    parameter int RESET_CYC    = 1250,
    parameter int INIT_CYC     = 250000000,
    parameter int BLINK_CYC    = 12500000,
    // One code point beyond the port range so an out-of-range select is expressible
    parameter int SEL_W        = $clog2(PORT_CNT) + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PORT_CNT-1:0] port_modprsl,
    input  logic [PORT_CNT-1:0] port_intl,
    output logic [PORT_CNT-1:0] port_resetl,
    output logic [PORT_CNT-1:0] port_modsell,
    output logic [PORT_CNT-1:0] port_lpmode,
    input  logic [PORT_CNT-1:0] sw_reset,
    input  logic [PORT_CNT-1:0] lpmode_req,
    input  logic                sel_valid,
    input  logic [SEL_W-1:0]    sel_port,
    output logic [PORT_CNT-1:0] present,
    output logic [PORT_CNT-1:0] ready,
    output logic [PORT_CNT-1:0] int_status,
    input  logic [PORT_CNT-1:0] int_clr,
    output logic [PORT_CNT-1:0] led_stat_g,
    output logic [PORT_CNT-1:0] led_stat_y
);

    localparam int c_MAX_A = (DEBOUNCE_CYC > RESET_CYC) ? DEBOUNCE_CYC : RESET_CYC;
    localparam int c_MAX   = (c_MAX_A > INIT_CYC) ? c_MAX_A : INIT_CYC;
    localparam int CNT_W   = $clog2(c_MAX + 1);

    localparam logic [CNT_W-1:0] c_DEB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] c_RST_LAST  = CNT_W'(RESET_CYC - 1);
    localparam logic [CNT_W-1:0] c_INIT_LAST = CNT_W'(INIT_CYC - 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX   = '1;

    typedef enum logic [1:0] {
        ST_ABSENT = 2'd0,
        ST_RESET  = 2'd1,
        ST_INIT   = 2'd2,
        ST_READY  = 2'd3
    } state_t;

`ifdef TAXI_QSFP_MGMT_LED_EN
    localparam int BLINK_W = $clog2(BLINK_CYC + 1);
    localparam logic [BLINK_W-1:0] c_BLINK_LAST = BLINK_W'(BLINK_CYC - 1);

    logic [BLINK_W-1:0] r_blink_cnt;
    logic               r_blink;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blink_cnt <= '0;
            r_blink     <= 1'b0;
        end else if (r_blink_cnt == c_BLINK_LAST) begin
            r_blink_cnt <= '0;
            r_blink     <= ~r_blink;
        end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
        end
    end
`endif

    for (genvar gi = 0; gi < PORT_CNT; gi++) begin : g_port
        logic             r_prs_s1, r_prs_s2;
        logic             r_int_s1, r_int_s2, r_int_d;
        logic [CNT_W-1:0] r_deb_cnt;
        logic             r_present;
        state_t           r_state, w_state_nxt;
        logic [CNT_W-1:0] r_seq_cnt, w_seq_cnt_nxt;
        logic             r_lpmode, r_modsell, r_int;
        logic             w_prs_now, w_int_fall, w_ready;

        assign w_prs_now  = ~r_prs_s2;
        assign w_int_fall = r_int_d & ~r_int_s2;
        assign w_ready    = (r_state == ST_READY);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_prs_s1  <= 1'b1;
                r_prs_s2  <= 1'b1;
                r_int_s1  <= 1'b1;
                r_int_s2  <= 1'b1;
                r_int_d   <= 1'b1;
                r_deb_cnt <= '0;
                r_present <= 1'b0;
            end else begin
                r_prs_s1 <= port_modprsl[gi];
                r_prs_s2 <= r_prs_s1;
                r_int_s1 <= port_intl[gi];
                r_int_s2 <= r_int_s1;
                r_int_d  <= r_int_s2;
                // Presence flips only after the synced pin disagrees for DEBOUNCE_CYC cycles in a row
                if (w_prs_now == r_present) begin
                    r_deb_cnt <= '0;
                end else if (r_deb_cnt == c_DEB_LAST) begin
                    r_present <= ~r_present;
                    r_deb_cnt <= '0;
                end else if (r_deb_cnt != c_CNT_MAX) begin
                    r_deb_cnt <= r_deb_cnt + 1'b1;
                end
            end
        end

        always_comb begin
            w_state_nxt   = r_state;
            w_seq_cnt_nxt = r_seq_cnt;
            if (r_seq_cnt != c_CNT_MAX) begin
                w_seq_cnt_nxt = r_seq_cnt + 1'b1;
            end
            case (r_state)
                ST_ABSENT: begin
                    w_seq_cnt_nxt = '0;
                    if (r_present) begin
                        w_state_nxt = ST_RESET;
                    end
                end
                ST_RESET: begin
                    if (r_seq_cnt == c_RST_LAST) begin
                        w_state_nxt   = ST_INIT;
                        w_seq_cnt_nxt = '0;
                    end
                end
                ST_INIT: begin
                    if (r_seq_cnt == c_INIT_LAST) begin
                        w_state_nxt   = ST_READY;
                        w_seq_cnt_nxt = '0;
                    end
                end
                ST_READY: begin
                    w_seq_cnt_nxt = '0;
                end
                default: begin
                    w_state_nxt   = ST_ABSENT;
                    w_seq_cnt_nxt = '0;
                end
            endcase
            if ((r_state != ST_ABSENT) && sw_reset[gi]) begin
                w_state_nxt   = ST_RESET;
                w_seq_cnt_nxt = '0;
            end
            // Removal takes priority over everything else
            if (!r_present) begin
                w_state_nxt   = ST_ABSENT;
                w_seq_cnt_nxt = '0;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state   <= ST_ABSENT;
                r_seq_cnt <= '0;
                r_lpmode  <= 1'b1;
                r_modsell <= 1'b1;
                r_int     <= 1'b0;
            end else begin
                r_state   <= w_state_nxt;
                r_seq_cnt <= w_seq_cnt_nxt;
                r_lpmode  <= (w_state_nxt == ST_READY) ? lpmode_req[gi] : 1'b1;
                r_modsell <= ~(sel_valid && (sel_port == SEL_W'(gi)) && w_ready);
                if (w_ready && (w_state_nxt == ST_READY)) begin
                    if (w_int_fall) begin
                        r_int <= 1'b1;
                    end else if (int_clr[gi]) begin
                        r_int <= 1'b0;
                    end
                end else begin
                    r_int <= 1'b0;
                end
            end
        end

        assign port_resetl[gi]  = (r_state == ST_INIT) || w_ready;
        assign port_lpmode[gi]  = r_lpmode;
        assign port_modsell[gi] = r_modsell;
        assign present[gi]      = r_present;
        assign ready[gi]        = w_ready;
        assign int_status[gi]   = r_int;

`ifdef TAXI_QSFP_MGMT_LED_EN
        assign led_stat_g[gi] = w_ready;
        assign led_stat_y[gi] = w_ready ? r_int :
                                ((r_state == ST_RESET) || (r_state == ST_INIT)) ? r_blink : 1'b0;
`else
        assign led_stat_g[gi] = 1'b0;
        assign led_stat_y[gi] = 1'b0;
`endif
    end

endmodule

`default_nettype wire

// File: tb/tb_taxi_qsfp_mgmt_seq.sv
// tb_taxi_qsfp_mgmt_seq: directed scoreboard bench for the QSFP sideband sequencer
// (short timing parameters, two ports).
`default_nettype none

module tb_taxi_qsfp_mgmt_seq;

    localparam int PORT_CNT = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] modprsl, intl, sw_reset, lpmode_req, int_clr;
    logic       sel_valid;
    logic [1:0] sel_port;
    logic [1:0] resetl, modsell, lpmode, present, ready, int_status, led_g, led_y;

    taxi_qsfp_mgmt_seq #(
        .PORT_CNT    (PORT_CNT),
        .DEBOUNCE_CYC(8),
        .RESET_CYC   (4),
        .INIT_CYC    (16),
        .BLINK_CYC   (4)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .port_modprsl(modprsl),
        .port_intl   (intl),
        .port_resetl (resetl),
        .port_modsell(modsell),
        .port_lpmode (lpmode),
        .sw_reset    (sw_reset),
        .lpmode_req  (lpmode_req),
        .sel_valid   (sel_valid),
        .sel_port    (sel_port),
        .present     (present),
        .ready       (ready),
        .int_status  (int_status),
        .int_clr     (int_clr),
        .led_stat_g  (led_g),
        .led_stat_y  (led_y)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic chk(input logic [31:0] obs);
        exp_t e;
        n_vec++;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard_empty observed=%0h expected=none", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val)
            else begin
                n_err++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; modprsl = 2'b11; intl = 2'b11; sw_reset = 2'b00;
        lpmode_req = 2'b00; int_clr = 2'b00; sel_valid = 1'b0; sel_port = 2'd0;
        tick(3);
        push("rst_present", 0); push("rst_ready", 0); push("rst_resetl", 0);
        push("rst_modsell", 3); push("rst_lpmode", 3); push("rst_int", 0); push("rst_leds", 0);
        chk(present); chk(ready); chk(resetl); chk(modsell); chk(lpmode); chk(int_status); chk({led_g, led_y});
        rst_n = 1'b1;
        tick(2);

        // Insert port 0: presence after 2+8 edges, 4-cycle reset hold, 16-cycle t_init
        modprsl = 2'b10;
        push("ins_pres_early", 0); tick(9);  chk(present);
        push("ins_pres", 1);       tick(1);  chk(present);
        push("ins_rst_hold", 0);   tick(4);  chk(resetl);
        push("ins_rst_rel", 1);    tick(1);  chk(resetl);
        push("ins_lp_init", 3);    chk(lpmode);
        push("ins_not_ready", 0);  tick(15); chk(ready);
        push("ins_ready", 1);      tick(1);  chk(ready);
        push("ins_lp_ready", 2);   chk(lpmode);
        push("ins_p1_idle", 0);    chk({present[1], resetl[1], ready[1], int_status[1]});

        lpmode_req = 2'b01; push("lp_req_hi", 3); tick(1); chk(lpmode);
        lpmode_req = 2'b00; push("lp_req_lo", 2); tick(1); chk(lpmode);

        // Software reset from READY
        sw_reset = 2'b01;
        push("sw_ready_drop", 0); push("sw_resetl_low", 0);
        tick(1); sw_reset = 2'b00;
        chk(ready); chk(resetl);
        push("sw_hold", 0);  tick(3);  chk(resetl);
        push("sw_rel", 1);   tick(1);  chk(resetl);
        push("sw_init", 0);  tick(15); chk(ready);
        push("sw_ready", 1); tick(1);  chk(ready);

        // Bring port 1 up
        modprsl = 2'b00;
        push("p1_ready", 3); tick(31); chk(ready);

        // Management-bus select
        sel_valid = 1'b1; sel_port = 2'd1; push("sel_p1", 2'b01); tick(1); chk(modsell);
        sel_port = 2'd0;                   push("sel_p0", 2'b10); tick(1); chk(modsell);
        sel_port = 2'd3;                   push("sel_oor", 2'b11); tick(1); chk(modsell);
        sel_valid = 1'b0; sel_port = 2'd1; push("sel_idle", 2'b11); tick(1); chk(modsell);

        // Interrupts on port 1
        intl = 2'b01; push("int_set", 2); tick(1); intl = 2'b11; tick(3); chk(int_status);
        intl = 2'b01; push("int_set_beats_clr", 2);
        tick(1); intl = 2'b11; tick(1); int_clr = 2'b10; tick(1); int_clr = 2'b00;
        chk(int_status);
        int_clr = 2'b10; push("int_clr", 0); tick(1); int_clr = 2'b00; chk(int_status);
        intl = 2'b01; push("int_set2", 2); tick(1); intl = 2'b11; tick(3); chk(int_status);
        sw_reset = 2'b10; push("int_leave_ready", 0); tick(1); sw_reset = 2'b00; chk(int_status);

        // Remove port 0 while it is in INIT
        sw_reset = 2'b01; modprsl = 2'b01;
        tick(1); sw_reset = 2'b00;
        push("rm_init_resetl", 1); push("rm_pres_gone", 0);
        tick(9); chk(resetl[0]); chk(present[0]);
        push("rm_resetl", 0); push("rm_lpmode", 1); push("rm_ready", 0);
        tick(1); chk(resetl[0]); chk(lpmode[0]); chk(ready[0]);
        push("rm_stay_absent", 0); tick(14); chk(ready[0]);
        sel_valid = 1'b1; sel_port = 2'd0; push("sel_absent", 2'b11); tick(1); chk(modsell);
        sel_valid = 1'b0;

        // Bouncing ModPrsL never reaches the debounce threshold
        for (int k = 0; k < 8; k++) begin
            modprsl[0] = k[0];
            push("bnc_pres", 0); push("bnc_resetl", 0);
            tick(5);
            chk(present[0]); chk(resetl[0]);
        end
        tick(3);

        // Re-insert runs the whole sequence again
        modprsl[0] = 1'b0;
        push("re_pres_early", 0); tick(9);  chk(present[0]);
        push("re_pres", 1);       tick(1);  chk(present[0]);
        push("re_hold", 0);       tick(4);  chk(resetl[0]);
        push("re_rel", 1);        tick(1);  chk(resetl[0]);
        push("re_not_ready", 0);  tick(15); chk(ready[0]);
        push("re_ready", 1);      tick(1);  chk(ready[0]);

        // Asynchronous reset in the middle of activity
        sel_valid = 1'b1; sel_port = 2'd1; lpmode_req = 2'b11;
        push("pre_rst_modsell", 2'b01); tick(1); chk(modsell);
        sw_reset = 2'b01; tick(1); sw_reset = 2'b00; tick(2);
        #2 rst_n = 1'b0;
        #1;
        push("arst_present", 0); push("arst_ready", 0); push("arst_resetl", 0);
        push("arst_modsell", 3); push("arst_lpmode", 3); push("arst_int", 0); push("arst_leds", 0);
        chk(present); chk(ready); chk(resetl); chk(modsell); chk(lpmode); chk(int_status); chk({led_g, led_y});
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
